// File: rtl/riscv_pkg.sv
// Shared core package: arbiter state encoding and memory mux select codes.
package riscv_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_GNT_I = 2'd1;
    localparam arb_state_t ARB_GNT_D = 2'd2;

    localparam logic SEL_IF   = 1'b0;
    localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational two-way picker between the fetch and data ports.
//  if_elig / d_elig   in   eligibility of each port this cycle
//  last_tie_winner    in   winner of the previous tie (0 = IF, 1 = data)
//  if_gnt / d_gnt     out  one-hot (or zero) grant
//  tie                out  both ports eligible this cycle
// DATA_PRIO=1: data wins every tie. DATA_PRIO=0: the loser of the last tie wins.
module arb_pick #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic if_elig,
    input  logic d_elig,
    input  logic last_tie_winner,
    output logic if_gnt,
    output logic d_gnt,
    output logic tie
);

    always_comb begin
        tie    = if_elig & d_elig;
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (tie) begin
            if (DATA_PRIO) begin
                d_gnt = 1'b1;
            end else begin
                d_gnt  = ~last_tie_winner;
                if_gnt = last_tie_winner;
            end
        end else begin
            if_gnt = if_elig;
            d_gnt  = d_elig;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory between IF and MEM.
// One owner per cycle; the memory answers the cycle after the access, so the
// registered owner of the last cycle is also the port acked this cycle.
// Ports:
//  clk, rst (sync, active low)
//  if_req/if_addr              fetch request (held until if_ack)
//  d_req/d_we/d_addr/d_wdata   data request (held until d_ack)
//  mem_sel/mem_en/mem_we       memory mux select, access strobe, write enable
//  mem_rdata -> rdata          read data passthrough, qualify with an ack
//  if_ack/d_ack                access completed (one cycle)
//  if_stall                    fetch requested but not granted this cycle
//  conflict_cnt                saturating count of cycles IF lost to data
//                              (only when MEM_ARB_PERF_EN is defined)
// Addresses and store data route through external muxes; only their select
// is generated here.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DATA_PRIO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          mem_sel,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          if_ack,
    output logic          d_ack,
    output logic          if_stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   conflict_cnt
`endif
);

    arb_state_t state_q, state_d;
    logic       last_tie_q, last_tie_d;
    logic       if_elig, d_elig;
    logic       pick_if, pick_d, pick_tie;
    logic       if_gnt, d_gnt;

    // Addresses and wdata are muxed outside; keep them on the port list only.
    logic unused_inputs;
    assign unused_inputs = ^{if_addr, d_addr, d_wdata};

    // The port owning the current ack cycle is masked so a req still high
    // during its ack is never granted twice.
    assign if_elig = if_req & (state_q != ARB_GNT_I);
    assign d_elig  = d_req  & (state_q != ARB_GNT_D);

    arb_pick #(
        .DATA_PRIO (DATA_PRIO != 0)
    ) u_pick (
        .if_elig         (if_elig),
        .d_elig          (d_elig),
        .last_tie_winner (last_tie_q),
        .if_gnt          (pick_if),
        .d_gnt           (pick_d),
        .tie             (pick_tie)
    );

    // No access may start while reset is held.
    assign if_gnt = pick_if & rst;
    assign d_gnt  = pick_d  & rst;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            last_tie_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_tie_q <= last_tie_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = ARB_IDLE;
        last_tie_d = last_tie_q;
        if (d_gnt) begin
            state_d = ARB_GNT_D;
        end else if (if_gnt) begin
            state_d = ARB_GNT_I;
        end
        if (pick_tie & rst) begin
            last_tie_d = d_gnt;
        end
    end

    // Outputs. Acks are gated by rst so an access in flight when reset
    // arrives is dropped rather than acknowledged.
    always_comb begin
        mem_en   = if_gnt | d_gnt;
        mem_sel  = d_gnt ? SEL_DATA : SEL_IF;
        mem_we   = d_we & d_gnt;
        if_stall = if_req & ~if_gnt;
        if_ack   = rst & (state_q == ARB_GNT_I);
        d_ack    = rst & (state_q == ARB_GNT_D);
        rdata    = mem_rdata;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_req & ~if_gnt & d_gnt & (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    // p_ = DATA_PRIO=1 instance, r_ = DATA_PRIO=0 instance; same stimulus.
    logic        p_sel, p_en, p_we, p_ia, p_da, p_st;
    logic        r_sel, r_en, r_we, r_ia, r_da, r_st;
    logic [31:0] p_rd, r_rd;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] p_cc, r_cc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1)) u_p (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_sel(p_sel), .mem_en(p_en), .mem_we(p_we), .mem_rdata(mem_rdata),
        .rdata(p_rd), .if_ack(p_ia), .d_ack(p_da), .if_stall(p_st)
`ifdef MEM_ARB_PERF_EN
        , .conflict_cnt(p_cc)
`endif
    );

    mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0)) u_r (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_sel(r_sel), .mem_en(r_en), .mem_we(r_we), .mem_rdata(mem_rdata),
        .rdata(r_rd), .if_ack(r_ia), .d_ack(r_da), .if_stall(r_st)
`ifdef MEM_ARB_PERF_EN
        , .conflict_cnt(r_cc)
`endif
    );

    // Reference model: who was granted last cycle (0 none, 1 fetch, 2 data),
    // who won the last tie (1 = data), and the conflict count.
    int          m_own [2];
    bit          m_last[2];
    longint      m_cnt [2];
    bit          eg_i[2], eg_d[2], e_tie[2];

    // Values sampled at the negedge of the most recent cycle.
    bit s_pia, s_pda, s_rsel, s_ren, s_psel;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_eval(int k);
        bit ie, de;
        ie = if_req && (m_own[k] != 1);
        de = d_req  && (m_own[k] != 2);
        eg_i[k]  = 1'b0;
        eg_d[k]  = 1'b0;
        e_tie[k] = 1'b0;
        if (rst) begin
            if (ie && de) begin
                e_tie[k] = 1'b1;
                // k==0 gives data priority; k==1 lets the last tie's loser win
                if (k == 0 || !m_last[k]) eg_d[k] = 1'b1;
                else                      eg_i[k] = 1'b1;
            end else begin
                eg_i[k] = ie;
                eg_d[k] = de;
            end
        end
    endtask

    task automatic model_step(int k);
        if (!rst) begin
            m_own[k]  = 0;
            m_last[k] = 1'b0;
            m_cnt[k]  = 0;
        end else begin
            if (if_req && !eg_i[k] && eg_d[k] && m_cnt[k] < 64'hFFFF_FFFF)
                m_cnt[k] = m_cnt[k] + 1;
            if (e_tie[k]) m_last[k] = eg_d[k];
            m_own[k] = eg_d[k] ? 2 : (eg_i[k] ? 1 : 0);
        end
    endtask

    task automatic check_dut(int k, string pf, logic en, logic sel, logic we,
                             logic st, logic ia, logic da, logic [31:0] rd);
        chk({pf, "_en"},    en,  eg_i[k] | eg_d[k]);
        chk({pf, "_sel"},   sel, eg_d[k]);
        chk({pf, "_we"},    we,  eg_d[k] & d_we);
        chk({pf, "_stall"}, st,  if_req & ~eg_i[k]);
        chk({pf, "_ifack"}, ia,  rst && m_own[k] == 1);
        chk({pf, "_dack"},  da,  rst && m_own[k] == 2);
        chk({pf, "_rdata"}, rd,  mem_rdata);
    endtask

    // Drive one cycle's inputs just after a posedge, check at the negedge,
    // advance the model on the next posedge.
    task automatic cyc(bit r, bit ir, bit dr, bit we, logic [31:0] rdv);
        rst = r; if_req = ir; d_req = dr; d_we = we; mem_rdata = rdv;
        @(negedge clk);
        model_eval(0);
        model_eval(1);
        check_dut(0, "p", p_en, p_sel, p_we, p_st, p_ia, p_da, p_rd);
        check_dut(1, "r", r_en, r_sel, r_we, r_st, r_ia, r_da, r_rd);
`ifdef MEM_ARB_PERF_EN
        chk("p_cnt", p_cc, m_cnt[0][31:0]);
        chk("r_cnt", r_cc, m_cnt[1][31:0]);
`endif
        s_pia = p_ia; s_pda = p_da; s_psel = p_sel;
        s_rsel = r_sel; s_ren = r_en;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    int acks, repeats, prev;

    initial begin
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_last[k] = 1'b0; m_cnt[k] = 0;
        end
        @(posedge clk); #1;

        // 1: reset held with fetch pending, then first grant to IF
        cyc(0, 1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 32'h0);
        chk("t1_first_sel_if", s_psel, 1'b0);
        cyc(1, 0, 0, 0, 32'h1234);
        chk("t1_ifack", s_pia, 1'b1);

        // 2: lone fetch
        if_addr = 32'h100;
        cyc(1, 1, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h00500093);
        chk("t2_ifack", s_pia, 1'b1);
        cyc(1, 0, 0, 0, 32'h0);

        // 3: tie with a store, data priority
        d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        cyc(1, 1, 1, 1, 32'h0);
        cyc(1, 1, 0, 0, 32'h0);
        chk("t3_dack", s_pda, 1'b1);
        cyc(1, 0, 0, 0, 32'h0);
        chk("t3_ifack", s_pia, 1'b1);
        cyc(1, 0, 0, 0, 32'h0);

        // 4: sustained contention for 10 cycles, plus one drain cycle
        acks = 0; repeats = 0; prev = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1, i < 10, i < 10, 0, $urandom);
            if (i > 0) begin
                if (s_pia) begin acks++; if (prev == 1) repeats++; prev = 1; end
                if (s_pda) begin acks++; if (prev == 2) repeats++; prev = 2; end
            end
        end
        chk("t4_acks", acks, 10);
        chk("t4_repeats", repeats, 0);

        // 5: isolated ties on the round-robin instance after a fresh reset
        cyc(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 32'h0);
            chk("t5_rr_win", s_rsel, (i % 2 == 0) ? 1'b1 : 1'b0);
            cyc(1, 0, 0, 0, 32'h0);
            cyc(1, 0, 0, 0, 32'h0);
        end

        // 6: reset arrives the cycle after a data grant
        cyc(1, 1, 1, 0, 32'h0);
        cyc(0, 1, 1, 0, 32'h0);
        chk("t6_dack_dropped", s_pda, 1'b0);
        cyc(1, 0, 0, 0, 32'h0);
        chk("t6_idle_dack", s_pda, 1'b0);
        chk("t6_idle_ifack", s_pia, 1'b0);

        // Random traffic, with occasional resets
        for (int i = 0; i < 400; i++) begin
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            cyc(($urandom_range(0, 24) != 0), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
